// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one word read at a time to instruction memory and
// hands each instruction to decode over valid/ready. Redirects squash the current stream.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            drop_q, drop_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= INSTR_NOP;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Request is masked while reset is held so memory never sees a request during reset.
    always_comb begin
        mem_req_valid = reset && (state_q == FETCH_REQ);
        mem_req_addr  = pc_q;
        instr_valid   = (state_q == FETCH_HOLD);
        instr         = instr_q;
        instr_pc      = instr_pc_q;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            FETCH_REQ: begin
                if (mem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d    = FETCH_HOLD;
                        instr_d    = mem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + PC_STEP;
                    end
                end
            end
            FETCH_HOLD: begin
                if (instr_ready) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        // A request already handed to memory still owes a response; drop_pending swallows it.
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            state_d    = FETCH_REQ;
            drop_d     = 1'b0;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            if ((state_q == FETCH_REQ && mem_req_ready) ||
                (state_q == FETCH_WAIT && !mem_rsp_valid)) begin
                state_d = FETCH_WAIT;
                drop_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: transaction-level model with per-cycle compare plus directed
// scenarios with literal expectations; a second instance covers PC wrap and mid-fetch reset.
module tb_instruction_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;
    localparam logic [31:0] SCRAMBLE = 32'h1357_9BDF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, redirect_valid, mem_req_valid, mem_req_ready, instr_valid, instr_ready;
    logic [31:0] redirect_pc, mem_req_addr, instr, instr_pc;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = 32'h0;

    logic        w_reset, w_mem_req_valid, w_mem_req_ready, w_instr_valid, w_instr_ready;
    logic [31:0] w_mem_req_addr, w_instr, w_instr_pc;
    logic        w_mem_rsp_valid = 1'b0;
    logic [31:0] w_mem_rsp_data  = 32'h0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc    = 32'h0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) u_dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC), .XLEN(32)) u_wrap (
        .clk(clk), .reset(w_reset), .redirect_valid(w_redirect_valid),
        .redirect_pc(w_redirect_pc), .mem_req_valid(w_mem_req_valid),
        .mem_req_ready(w_mem_req_ready), .mem_req_addr(w_mem_req_addr),
        .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_data(w_mem_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
        .instr_pc(w_instr_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] addr; bit live; } req_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;

    req_t        out_q[$];
    rsp_t        mem_q[$];
    logic [31:0] imem [logic [31:0]];
    int          mem_lat = 1;
    int          cyc = 0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_instr = NOP;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_next = 32'h0;
    logic [31:0] del_pc[$], del_instr[$], req_log[$], w_del_pc[$], w_del_instr[$];
    int          req_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return a ^ SCRAMBLE;
    endfunction

    // Model of the fetch stream plus the bench's instruction memory (latency mem_lat >= 1).
    always begin : model
        bit          s_reset, s_redir, s_acc, s_rsp, s_hs;
        logic [31:0] s_rpc, s_addr, s_data, s_ipc, s_instr;
        req_t        r;
        @(posedge clk);
        s_reset = reset;            s_redir = redirect_valid;  s_rpc   = redirect_pc;
        s_acc   = mem_req_valid && mem_req_ready;              s_addr  = mem_req_addr;
        s_rsp   = mem_rsp_valid;    s_data  = mem_rsp_data;
        s_hs    = instr_valid && instr_ready;
        s_ipc   = instr_pc;         s_instr = instr;
        cyc++;
        if (!s_reset) begin
            exp_valid = 1'b0;
            exp_next  = 32'h0;
            out_q.delete();
            mem_q.delete();
        end else begin
            if (exp_valid && s_hs && !s_redir) begin
                del_pc.push_back(s_ipc);
                del_instr.push_back(s_instr);
                exp_valid = 1'b0;
            end
            if (s_rsp && out_q.size() > 0) begin
                r = out_q.pop_front();
                void'(mem_q.pop_front());
                if (r.live && !s_redir) begin
                    exp_valid = 1'b1;
                    exp_instr = s_data;
                    exp_pc    = r.addr;
                    exp_next  = r.addr + 32'd4;
                end
            end
            if (s_acc) begin
                req_log.push_back(s_addr);
                req_cyc.push_back(cyc);
                out_q.push_back('{addr: s_addr, live: 1'b1});
                mem_q.push_back('{data: mem_word(s_addr), due: cyc + mem_lat - 1});
            end
            if (s_redir) begin
                foreach (out_q[i]) out_q[i].live = 1'b0;
                exp_valid = 1'b0;
                exp_next  = {s_rpc[31:2], 2'b00};
            end
        end
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_q[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
    end

    always @(negedge clk) begin : compare
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("instr", instr, exp_instr);
            check("instr_pc", instr_pc, exp_pc);
        end
        check("mem_req_valid", {31'b0, mem_req_valid},
              {31'b0, (reset && !exp_valid && (out_q.size() == 0))});
        if (mem_req_valid || !reset) check("mem_req_addr", mem_req_addr, exp_next);
    end

    // Zero-wait memory for the wrap instance; it forgets its request when reset is sampled.
    always begin : wrap_mem
        bit          acc;
        logic [31:0] a;
        @(posedge clk);
        acc = w_reset && w_mem_req_valid && w_mem_req_ready;
        a   = w_mem_req_addr;
        if (w_reset && w_instr_valid && w_instr_ready) begin
            w_del_pc.push_back(w_instr_pc);
            w_del_instr.push_back(w_instr);
        end
        #1;
        w_mem_rsp_valid = acc;
        w_mem_rsp_data  = acc ? (a ^ SCRAMBLE) : 32'h0;
    end

    task automatic wait_req(input int n);
        int t = 0;
        while (req_log.size() < n && t < 100) begin
            @(posedge clk); #2; t++;
        end
        if (req_log.size() < n) check("timeout_req", req_log.size(), n);
    endtask

    task automatic wait_del(input int n);
        int t = 0;
        while (del_pc.size() < n && t < 100) begin
            @(posedge clk); #2; t++;
        end
        if (del_pc.size() < n) check("timeout_del", del_pc.size(), n);
    endtask

    task automatic wait_instr_valid();
        int t = 0;
        @(negedge clk);
        while (!instr_valid && t < 100) begin
            @(negedge clk); t++;
        end
        if (!instr_valid) check("timeout_instr_valid", {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        int beef;
        int t;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        w_reset = 1'b0; w_mem_req_ready = 1'b1; w_instr_ready = 1'b1;
        imem[32'h0] = 32'h0050_0093;
        imem[32'h4] = 32'h00A0_0113;
        imem[32'h8] = 32'h0010_0193;
        imem[32'hC] = 32'hDEAD_BEEF;

        // Reset values, then first cycle after release.
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b1;
        #1;
        check("t1_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("t1_req_addr", mem_req_addr, 32'h0);

        // Zero-wait stream.
        wait_del(2);
        wait_req(3);
        check("t2_del0_pc", del_pc[0], 32'h0);
        check("t2_del0_instr", del_instr[0], 32'h0050_0093);
        check("t2_del1_pc", del_pc[1], 32'h4);
        check("t2_del1_instr", del_instr[1], 32'h00A0_0113);
        check("t2_req0", req_log[0], 32'h0);
        check("t2_req1", req_log[1], 32'h4);
        check("t2_req2", req_log[2], 32'h8);
        check("t2_req_spacing", req_cyc[1] - req_cyc[0], 32'd3);

        // Decode stall in FETCH_HOLD.
        instr_ready = 1'b0;
        wait_instr_valid();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {31'b0, instr_valid}, 32'd1);
            check("t3_hold_instr", instr, 32'h0010_0193);
            check("t3_hold_pc", instr_pc, 32'h8);
            check("t3_no_req", {31'b0, mem_req_valid}, 32'd0);
            @(negedge clk);
        end
        mem_lat = 3;
        instr_ready = 1'b1;

        // Redirect while waiting on a slow response that must be discarded.
        wait_req(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        mem_lat = 1;
        wait_req(5);
        check("t4_req_after_redirect", req_log[4], 32'h100);
        check("t4_req_spacing", req_cyc[4] - req_cyc[3], 32'd4);

        // Redirect in FETCH_HOLD with decode ready in the same cycle.
        wait_instr_valid();
        check("t5_hold_pc", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        check("t5_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("t5_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("t5_req_addr", mem_req_addr, 32'h200);
        check("t5_del_count", del_pc.size(), 32'd3);
        wait_del(4);
        check("t5_del_pc", del_pc[3], 32'h200);
        check("t5_del_instr", del_instr[3], 32'h1357_99DF);
        beef = 0;
        foreach (del_instr[i]) if (del_instr[i] == 32'hDEAD_BEEF) beef++;
        check("t4_no_stale_rsp", beef, 32'd0);

        // Memory backpressure, then redirect on the cycle the request is accepted.
        mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0302;
        mem_req_ready = 1'b1;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_req(8);
        check("t7_req_dropped", req_log[6], 32'h204);
        check("t7_req_redirect", req_log[7], 32'h300);
        wait_del(5);
        check("t7_del_pc", del_pc[4], 32'h300);

        // PC wrap on the second instance, then reset during FETCH_WAIT.
        w_reset = 1'b1;
        t = 0;
        while (w_del_pc.size() < 2 && t < 100) begin
            @(posedge clk); #2; t++;
        end
        check("t6_del_count", w_del_pc.size(), 32'd2);
        check("t6_del0_pc", w_del_pc[0], WRAP_PC);
        check("t6_del0_instr", w_del_instr[0], 32'hECA8_6423);
        check("t6_del1_pc", w_del_pc[1], 32'h0);
        check("t6_del1_instr", w_del_instr[1], 32'h1357_9BDF);
        t = 0;
        @(negedge clk);
        while (!w_mem_req_valid && t < 100) begin
            @(negedge clk); t++;
        end
        check("t6_req_seen", {31'b0, w_mem_req_valid}, 32'd1);
        @(posedge clk); #2;
        w_reset = 1'b0;
        @(posedge clk); #2;
        check("t6_rst_instr_valid", {31'b0, w_instr_valid}, 32'd0);
        check("t6_rst_req_valid", {31'b0, w_mem_req_valid}, 32'd0);
        check("t6_rst_req_addr", w_mem_req_addr, WRAP_PC);
        check("t6_rst_instr", w_instr, NOP);
        @(posedge clk); #2;
        w_reset = 1'b1;
        #1;
        check("t6_rel_req_valid", {31'b0, w_mem_req_valid}, 32'd1);
        check("t6_rel_req_addr", w_mem_req_addr, WRAP_PC);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
